// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lane_pkg
//  Description : Shared types and constants for the lane traffic controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package lane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FULL  = 2'd3
    } lane_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam int          CAR_WIDTH    = 48;
    localparam int          GAP_WIDTH    = 8;

    // Minimum frames between spawns per speed, packed so entry s sits at [8s+7:8s].
    localparam logic [63:0] GAP_BASE = {8'd16, 8'd19, 8'd23, 8'd28,
                                        8'd38, 8'd56, 8'd112, 8'd32};

    function automatic logic [GAP_WIDTH-1:0] gap_base(input logic [2:0] speed);
        return GAP_BASE[8*speed +: 8];
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_spawner_hit_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : hit_debounce
//  Description : Masked hit vector to one-frame pulse with cooldown immunity.
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_debounce #(
    parameter int NUM_CARS = 4,
    parameter int COOLDOWN = 60
) (
    input  logic                FrameClk,
    input  logic                ResetN,
    input  logic                clear_i,
    input  logic [NUM_CARS-1:0] hit_i,
    input  logic [NUM_CARS-1:0] mask_i,
    output logic                pulse_o
);

    localparam int            CW      = $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

    logic [CW-1:0] cd_q, cd_d;
    logic          pulse_q, pulse_d;
    logic          hit_any;

    assign hit_any = |(hit_i & mask_i);

    always_comb begin
        pulse_d = 1'b0;
        cd_d    = cd_q;
        if (clear_i) begin
            cd_d = '0;
        end else if (hit_any && (cd_q == '0)) begin
            pulse_d = 1'b1;
            cd_d    = CD_LOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - CW'(1);
        end
    end

    always_ff @(posedge FrameClk) begin
        if (!ResetN) begin
            cd_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            cd_q    <= cd_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/lane_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : lane_spawner
//  Description : Staggers car spawns in one lane and debounces player hits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_spawner
    import lane_pkg::*;
#(
    parameter int          NUM_CARS  = 4,
    parameter logic [9:0]  LANE_Y    = 10'd0,
    parameter logic [9:0]  SPAWN_X   = 10'd52,
    parameter logic        FACE_LEFT = 1'b0,
    parameter int          COOLDOWN  = 60
) (
    input  logic                  FrameClk,
    input  logic                  ResetN,
    input  logic                  Enable,
    input  logic [15:0]           Seed,
    input  logic [2:0]            Speed,
    input  logic [NUM_CARS-1:0]   P1HitIn,
    input  logic [NUM_CARS-1:0]   P2HitIn,
    output logic [NUM_CARS-1:0]   SpawnEnable,
    output logic [2*NUM_CARS-1:0] TypeBus,
    output logic [9:0]            SpawnX,
    output logic [9:0]            SpawnY,
    output logic                  FaceLeft,
    output logic [2:0]            CarSpeed,
    output logic                  P1Hit,
    output logic                  P2Hit,
    output logic                  Full
);

    localparam int            KW     = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CARS - 1);

    lane_state_t              state_q, state_d;
    logic [15:0]              lfsr_q;
    logic [KW-1:0]            k_q, k_d;
    logic [GAP_WIDTH-1:0]     gap_q, gap_d;
    logic [GAP_WIDTH-1:0]     gap_load;
    logic [NUM_CARS-1:0]      spawn_q, spawn_d;
    logic [2*NUM_CARS-1:0]    type_q, type_d;
    logic                     full_q, full_d;

    // Speed is sampled only here, so a change mid-wait affects the next gap only.
    assign gap_load = gap_base(Speed) + {3'b000, lfsr_q[6:2]};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        spawn_d = spawn_q;
        type_d  = type_q;
        full_d  = full_q;
        if (!Enable) begin
            state_d = ST_IDLE;
            k_d     = '0;
            gap_d   = '0;
            spawn_d = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    k_d     = '0;
                    spawn_d = '0;
                    state_d = ST_SPAWN;
                end
                ST_SPAWN: begin
                    for (int s = 0; s < NUM_CARS; s++) begin
                        if (k_q == KW'(s)) begin
                            spawn_d[s]       = 1'b1;
                            type_d[2*s +: 2] = lfsr_q[1:0];
                        end
                    end
                    if (k_q == K_LAST) begin
                        full_d  = 1'b1;
                        state_d = ST_FULL;
                    end else begin
                        k_d     = k_q + KW'(1);
                        gap_d   = gap_load;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Leaving at count 2 puts the next rise exactly G frames after the last.
                    gap_d = gap_q - GAP_WIDTH'(1);
                    if (gap_q <= GAP_WIDTH'(2)) begin
                        state_d = ST_SPAWN;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge FrameClk) begin
        if (!ResetN) begin
            lfsr_q  <= (Seed == 16'h0000) ? LFSR_DEFAULT : Seed;
            state_q <= ST_IDLE;
            k_q     <= '0;
            gap_q   <= '0;
            spawn_q <= '0;
            type_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_next(lfsr_q);
            state_q <= state_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
            spawn_q <= spawn_d;
            type_q  <= type_d;
            full_q  <= full_d;
        end
    end

    hit_debounce #(
        .NUM_CARS (NUM_CARS),
        .COOLDOWN (COOLDOWN)
    ) u_hit_p1 (
        .FrameClk (FrameClk),
        .ResetN   (ResetN),
        .clear_i  (~Enable),
        .hit_i    (P1HitIn),
        .mask_i   (spawn_q),
        .pulse_o  (P1Hit)
    );

    hit_debounce #(
        .NUM_CARS (NUM_CARS),
        .COOLDOWN (COOLDOWN)
    ) u_hit_p2 (
        .FrameClk (FrameClk),
        .ResetN   (ResetN),
        .clear_i  (~Enable),
        .hit_i    (P2HitIn),
        .mask_i   (spawn_q),
        .pulse_o  (P2Hit)
    );

    assign SpawnEnable = spawn_q;
    assign TypeBus     = type_q;
    assign Full        = full_q;
    assign SpawnX      = SPAWN_X;
    assign SpawnY      = LANE_Y;
    assign FaceLeft    = FACE_LEFT;
    assign CarSpeed    = Speed;

endmodule
`default_nettype wire

// File: tb/tb_lane_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_spawner
//  Description : Directed self-checking bench for lane_spawner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_spawner;

    logic        FrameClk = 1'b0;
    logic        ResetN   = 1'b0;
    logic        Enable   = 1'b0;
    logic [15:0] Seed     = 16'h0000;
    logic [2:0]  Speed    = 3'd1;
    logic [3:0]  P1HitIn  = 4'b0000;
    logic [3:0]  P2HitIn  = 4'b0000;
    logic [3:0]  SpawnEnable;
    logic [7:0]  TypeBus;
    logic [9:0]  SpawnX, SpawnY;
    logic        FaceLeft;
    logic [2:0]  CarSpeed;
    logic        P1Hit, P2Hit, Full;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_lfsr   = 16'h0000;
    logic [15:0] prev_lfsr = 16'h0000;
    int          last_gap = 0;
    int          gb [8] = '{32, 112, 56, 38, 28, 23, 19, 16};
    logic [7:0]  saved_types;

    lane_spawner #(
        .NUM_CARS  (4),
        .LANE_Y    (10'd0),
        .SPAWN_X   (10'd52),
        .FACE_LEFT (1'b0),
        .COOLDOWN  (60)
    ) dut (
        .FrameClk    (FrameClk),
        .ResetN      (ResetN),
        .Enable      (Enable),
        .Seed        (Seed),
        .Speed       (Speed),
        .P1HitIn     (P1HitIn),
        .P2HitIn     (P2HitIn),
        .SpawnEnable (SpawnEnable),
        .TypeBus     (TypeBus),
        .SpawnX      (SpawnX),
        .SpawnY      (SpawnY),
        .FaceLeft    (FaceLeft),
        .CarSpeed    (CarSpeed),
        .P1Hit       (P1Hit),
        .P2Hit       (P2Hit),
        .Full        (Full)
    );

    always #5 FrameClk = ~FrameClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame: advance the reference LFSR with the reset level seen at the edge.
    task automatic tick();
        @(posedge FrameClk);
        prev_lfsr = m_lfsr;
        if (!ResetN) m_lfsr = (Seed == 16'h0000) ? 16'hACE1 : Seed;
        else         m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        #1;
    endtask

    task automatic wait_slot(input int k, input int exp_gap);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (SpawnEnable[k]) seen = 1'b1;
        end
        check($sformatf("rise_seen[%0d]", k), 32'(seen), 32'd1);
        check($sformatf("gap[%0d]", k), 32'(n), 32'(exp_gap));
        check($sformatf("type[%0d]", k), 32'(TypeBus[2*k +: 2]), 32'(prev_lfsr[1:0]));
        check($sformatf("se_mask[%0d]", k), 32'(SpawnEnable), 32'((1 << (k + 1)) - 1));
        check($sformatf("full[%0d]", k), 32'(Full), 32'(k == 3));
        last_gap = gb[Speed] + int'(prev_lfsr[6:2]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_se"},   32'(SpawnEnable), 32'h0);
        check({tag, "_type"}, 32'(TypeBus),     32'h0);
        check({tag, "_full"}, 32'(Full),        32'h0);
        check({tag, "_p1"},   32'(P1Hit),       32'h0);
        check({tag, "_p2"},   32'(P2Hit),       32'h0);
    endtask

    initial begin
        // Reset with a zero seed; default seed must be used.
        tick();
        tick();
        check_reset_outputs("rst");
        check("spawn_x",   32'(SpawnX),   32'd52);
        check("spawn_y",   32'(SpawnY),   32'd0);
        check("face_left", 32'(FaceLeft), 32'd0);
        check("car_speed", 32'(CarSpeed), 32'd1);
        check("model_seed", 32'(m_lfsr), 32'hACE1);

        ResetN = 1'b1;
        tick();
        check("idle_se", 32'(SpawnEnable), 32'h0);

        // Fill the lane at Speed 1: gaps 112..143.
        Enable = 1'b1;
        tick();
        check("lat_se", 32'(SpawnEnable), 32'h0);
        wait_slot(0, 1);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("gap_range[%0d]", k), 32'(last_gap >= 112 && last_gap <= 143), 32'd1);
            wait_slot(k, last_gap);
        end
        saved_types = TypeBus;
        tick();
        check("full_hold", 32'(Full), 32'd1);

        // Held hit on slot 0: one pulse per 61 frames.
        P1HitIn = 4'b0001;
        for (int i = 1; i <= 200; i++) begin
            tick();
            check($sformatf("p1_pulse@%0d", i), 32'(P1Hit), 32'((i % 61) == 1));
            check($sformatf("p2_quiet@%0d", i), 32'(P2Hit), 32'd0);
        end
        P1HitIn = 4'b0000;

        // Drop Enable in FULL: lane clears, types held.
        Enable = 1'b0;
        tick();
        check("drop_se",   32'(SpawnEnable), 32'h0);
        check("drop_full", 32'(Full),        32'h0);
        check("drop_type", 32'(TypeBus),     32'(saved_types));

        // Re-raise at Speed 7, drop again in WAIT after two slots.
        Speed  = 3'd7;
        Enable = 1'b1;
        wait_slot(0, 2);
        wait_slot(1, last_gap);
        P1HitIn = 4'b0100;
        P2HitIn = 4'b0010;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("p1_masked@%0d", i), 32'(P1Hit), 32'd0);
            check($sformatf("p2_pulse@%0d", i),  32'(P2Hit), 32'(i == 1));
        end
        P1HitIn = 4'b0000;
        P2HitIn = 4'b0000;
        Enable  = 1'b0;
        tick();
        check("wait_drop_se",   32'(SpawnEnable), 32'h0);
        check("wait_drop_full", 32'(Full),        32'h0);

        // Restart must begin again at slot 0.
        Enable = 1'b1;
        wait_slot(0, 2);
        for (int k = 1; k < 4; k++) wait_slot(k, last_gap);

        // Reset in FULL with a nonzero seed.
        Seed   = 16'h1235;
        ResetN = 1'b0;
        tick();
        check_reset_outputs("rst_full");
        check("model_seed2", 32'(m_lfsr), 32'h1235);
        ResetN = 1'b1;
        wait_slot(0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
